// File: rtl/conv_bn_relu_stage.sv
// -----------------------------------------------------------------------------
// conv_bn_relu_stage
//
// Per-output-channel batch-norm (y = x * scale + bias, Q-format) with optional
// ReLU. It is applied to the channel-summed pixel stream leaving the 1x1 conv
// adder chain. Pixels arrive channel-major: all IMAGE_SIZE pixels of channel 0,
// then channel 1, and so on. Coefficients stream in on the weight port as
// scale0, bias0, scale1, bias1, ... and land in a local buffer.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   valid_in        pxl_in valid
//   pxl_in          adder output pixel (signed, FRAC_BITS fractional bits)
//   valid_weight_in weight_in valid
//   weight_in       coefficient word (signed, FRAC_BITS fractional bits)
//   relu_en         1 = clamp negative results to 0; sampled with each pixel
//   pxl_out         normalised/activated pixel; holds while valid_out = 0
//   valid_out       pxl_out valid; fixed 3-cycle latency from valid_in
//   frame_done      1-cycle pulse with the last pixel of the last channel
//   coef_err        sticky: a pixel used a channel whose coefs were not loaded
// -----------------------------------------------------------------------------
module conv_bn_relu_stage #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned FRAC_BITS       = 8,
    parameter int unsigned IMAGE_WIDTH     = 306,
    parameter int unsigned IMAGE_HEIGHT    = 306,
    parameter int unsigned IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int unsigned CHANNEL_NUM_OUT = 512,
    parameter int unsigned COEF_ADDR_WIDTH = $clog2(2 * CHANNEL_NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  relu_en,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  coef_err
);

    localparam int unsigned COEF_DEPTH = 2 * CHANNEL_NUM_OUT;
    localparam int unsigned PIX_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned CH_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    // Loaded count must be able to hold COEF_DEPTH itself.
    localparam int unsigned CNT_W      = COEF_ADDR_WIDTH + 1;
    localparam int unsigned PROD_W     = 2 * DATA_WIDTH;
    // One guard bit above the full product so rounding and bias never wrap
    // before saturation.
    localparam int unsigned SUM_W      = PROD_W + 1;

    localparam logic [SUM_W-1:0] ROUND_CONST =
        (FRAC_BITS > 0) ? (SUM_W'(1) << (FRAC_BITS - 1)) : '0;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Coefficient buffer and load pointer
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]      coef_mem [COEF_DEPTH];
    logic [COEF_ADDR_WIDTH-1:0] wptr;
    logic [CNT_W-1:0]           loaded_cnt;

    // Contents are deliberately not reset; a reset only restarts the pointer.
    always_ff @(posedge clk) begin
        if (valid_weight_in) begin
            coef_mem[wptr] <= weight_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            loaded_cnt <= '0;
        end else if (valid_weight_in) begin
            if (wptr == COEF_ADDR_WIDTH'(COEF_DEPTH - 1)) begin
                wptr <= '0;
            end else begin
                wptr <= wptr + COEF_ADDR_WIDTH'(1);
            end
            if (loaded_cnt < CNT_W'(COEF_DEPTH)) begin
                loaded_cnt <= loaded_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel / channel position counters
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic             pix_last;
    logic             ch_last;

    always_comb begin
        pix_last = (pix_cnt == PIX_W'(IMAGE_SIZE - 1));
        ch_last  = (ch_cnt == CH_W'(CHANNEL_NUM_OUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (valid_in) begin
            if (pix_last) begin
                pix_cnt <= '0;
                ch_cnt  <= ch_last ? '0 : ch_cnt + CH_W'(1);
            end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient lookup for the current channel
    // ------------------------------------------------------------------
    logic [COEF_ADDR_WIDTH-1:0] scale_addr;
    logic [COEF_ADDR_WIDTH-1:0] bias_addr;
    logic [CNT_W-1:0]           coef_need;
    logic                       coef_ok;

    always_comb begin
        scale_addr = COEF_ADDR_WIDTH'({ch_cnt, 1'b0});
        bias_addr  = COEF_ADDR_WIDTH'({ch_cnt, 1'b1});
        // Channel c needs 2c+2 words written before it is trustworthy.
        coef_need  = CNT_W'({ch_cnt, 1'b0}) + CNT_W'(2);
        coef_ok    = (loaded_cnt >= coef_need);
    end

    // ------------------------------------------------------------------
    // S1: capture pixel, coefficients, relu flag and end-of-frame tag
    // ------------------------------------------------------------------
    logic                         s1_valid;
    logic                         s1_last;
    logic                         s1_relu;
    logic signed [DATA_WIDTH-1:0] s1_pxl;
    logic signed [DATA_WIDTH-1:0] s1_scale;
    logic signed [DATA_WIDTH-1:0] s1_bias;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            s1_pxl   <= '0;
            s1_scale <= '0;
            s1_bias  <= '0;
            coef_err <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s1_last  <= valid_in & pix_last & ch_last;
            if (valid_in) begin
                s1_relu  <= relu_en;
                s1_pxl   <= pxl_in;
                s1_scale <= coef_mem[scale_addr];
                s1_bias  <= coef_mem[bias_addr];
                if (!coef_ok) begin
                    coef_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: multiply, round half-up, add bias
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] pxl_ext;
    logic signed [PROD_W-1:0] scale_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  prod_rnd;
    logic signed [SUM_W-1:0]  prod_shr;
    logic signed [SUM_W-1:0]  bias_ext;
    logic signed [SUM_W-1:0]  bn_sum;

    always_comb begin
        pxl_ext   = {{(PROD_W - DATA_WIDTH){s1_pxl[DATA_WIDTH-1]}}, s1_pxl};
        scale_ext = {{(PROD_W - DATA_WIDTH){s1_scale[DATA_WIDTH-1]}}, s1_scale};
        prod      = pxl_ext * scale_ext;
        prod_rnd  = {prod[PROD_W-1], prod} + ROUND_CONST;
        prod_shr  = prod_rnd >>> FRAC_BITS;
        bias_ext  = {{(SUM_W - DATA_WIDTH){s1_bias[DATA_WIDTH-1]}}, s1_bias};
        bn_sum    = prod_shr + bias_ext;
    end

    logic                    s2_valid;
    logic                    s2_last;
    logic                    s2_relu;
    logic signed [SUM_W-1:0] s2_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_relu  <= 1'b0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_relu <= s1_relu;
                s2_sum  <= bn_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: saturate, optional ReLU, drive outputs
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] act_val;

    always_comb begin
        if (s2_relu && s2_sum[SUM_W-1]) begin
            act_val = '0;
        end else if (s2_sum > SAT_MAX) begin
            act_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (s2_sum < SAT_MIN) begin
            act_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            act_val = s2_sum[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= s2_valid;
            frame_done <= s2_valid & s2_last;
            if (s2_valid) begin
                pxl_out <= act_val;
            end
        end
    end

endmodule

// File: tb/tb_conv_bn_relu_stage.sv
// -----------------------------------------------------------------------------
// tb_conv_bn_relu_stage
//
// Directed bench for conv_bn_relu_stage with IMAGE_SIZE=4 (2x2) and two output
// channels. Each driven pixel pushes a hand-computed expected value and the
// cycle at which it must appear; a negedge checker matches outputs in order.
// -----------------------------------------------------------------------------
module tb_conv_bn_relu_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] pxl_in = '0;
    logic        valid_weight_in = 1'b0;
    logic [15:0] weight_in = '0;
    logic        relu_en = 1'b0;
    logic [15:0] pxl_out;
    logic        valid_out;
    logic        frame_done;
    logic        coef_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        logic        fd;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t got_e;

    conv_bn_relu_stage #(
        .DATA_WIDTH     (16),
        .FRAC_BITS      (8),
        .IMAGE_WIDTH    (2),
        .IMAGE_HEIGHT   (2),
        .CHANNEL_NUM_OUT(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .pxl_in         (pxl_in),
        .valid_weight_in(valid_weight_in),
        .weight_in      (weight_in),
        .relu_en        (relu_en),
        .pxl_out        (pxl_out),
        .valid_out      (valid_out),
        .frame_done     (frame_done),
        .coef_err       (coef_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output checker: in-order match against the expected queue, exact latency.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("extra_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("latency_cycle", 32'(cyc), 32'(got_e.due));
                    chk("pxl_out", 32'(pxl_out), 32'(got_e.data));
                    chk("frame_done", 32'(frame_done), 32'(got_e.fd));
                end
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("missing_valid_out", 32'(valid_out), 32'd1);
                    got_e = exp_q.pop_front();
                end
            end
        end
    end

    task automatic step_idle();
        @(posedge clk);
        #1;
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] w);
        @(posedge clk);
        #1;
        valid_in        = 1'b0;
        valid_weight_in = 1'b1;
        weight_in       = w;
    endtask

    task automatic load_all(input logic [15:0] s0, input logic [15:0] b0,
                            input logic [15:0] s1, input logic [15:0] b1);
        load_w(s0);
        load_w(b0);
        load_w(s1);
        load_w(b1);
    endtask

    task automatic send_pix(input logic [15:0] p, input logic r,
                            input logic [15:0] e, input logic fd);
        exp_t x;
        @(posedge clk);
        #1;
        valid_weight_in = 1'b0;
        valid_in        = 1'b1;
        pxl_in          = p;
        relu_en         = r;
        x.data = e;
        x.fd   = fd;
        x.due  = cyc + 3;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string tag);
        step_idle();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
        reset           = 1'b1;
        exp_q.delete();
        #1;
        chk({tag, "_pxl_out"}, 32'(pxl_out), 32'd0);
        chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_coef_err"}, 32'(coef_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_pxl_out", 32'(pxl_out), 32'd0);
        chk("por_valid_out", 32'(valid_out), 32'd0);
        chk("por_frame_done", 32'(frame_done), 32'd0);
        chk("por_coef_err", 32'(coef_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: scale0 2.0, bias0 0.5 -> 1.0*2+0.5 = 0x0280
        load_all(16'h0200, 16'h0080, 16'h0100, 16'hFF00);
        for (int i = 0; i < 4; i++) send_pix(16'h0100, 1'b0, 16'h0280, 1'b0);
        drain("t1_drain");

        // Test 2: ch1, 0.5*1.0-1.0 = -0.5; ReLU clamps, frame ends on 8th
        send_pix(16'h0080, 1'b1, 16'h0000, 1'b0);
        send_pix(16'h0080, 1'b1, 16'h0000, 1'b0);
        send_pix(16'h0080, 1'b0, 16'hFF80, 1'b0);
        send_pix(16'h0080, 1'b0, 16'hFF80, 1'b1);
        drain("t2_drain");
        step_idle();
        step_idle();
        chk("t2_hold_pxl_out", 32'(pxl_out), 32'h0000_FF80);
        chk("t2_hold_valid_out", 32'(valid_out), 32'd0);

        // Test 3: saturation on both rails, ch1 overflow and ReLU
        load_all(16'h7FFF, 16'h0000, 16'h0100, 16'hFF00);
        send_pix(16'h7FFF, 1'b0, 16'h7FFF, 1'b0);
        send_pix(16'h8000, 1'b0, 16'h8000, 1'b0);
        send_pix(16'h7FFF, 1'b1, 16'h7FFF, 1'b0);
        send_pix(16'h8000, 1'b1, 16'h0000, 1'b0);
        send_pix(16'h0300, 1'b0, 16'h0200, 1'b0);
        send_pix(16'h7FFF, 1'b0, 16'h7EFF, 1'b0);
        send_pix(16'h8000, 1'b0, 16'h8000, 1'b0);
        send_pix(16'hFF00, 1'b1, 16'h0000, 1'b1);
        drain("t3_drain");

        // Test 4: round half-up with scale 1.5
        load_all(16'h0180, 16'h0000, 16'h0100, 16'hFF00);
        send_pix(16'h0001, 1'b0, 16'h0002, 1'b0);
        send_pix(16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
        send_pix(16'h0002, 1'b0, 16'h0003, 1'b0);
        send_pix(16'hFFFE, 1'b0, 16'hFFFD, 1'b0);
        drain("t4_drain");

        // Test 6a: ch1 pixels with random gaps
        send_pix(16'h0100, 1'b0, 16'h0000, 1'b0);
        repeat ($urandom_range(0, 3)) step_idle();
        send_pix(16'h0280, 1'b0, 16'h0180, 1'b0);
        repeat ($urandom_range(0, 3)) step_idle();
        send_pix(16'h0040, 1'b0, 16'hFF40, 1'b0);
        repeat ($urandom_range(0, 3)) step_idle();
        send_pix(16'hFFC0, 1'b1, 16'h0000, 1'b1);
        drain("t6a_drain");
        chk("t6a_coef_err", 32'(coef_err), 32'd0);

        // Test 5: only ch0 coefs loaded after reset; ch1 buffer keeps old words
        do_reset("t5_reset");
        load_w(16'h0200);
        load_w(16'h0080);
        for (int i = 0; i < 4; i++) send_pix(16'h0100, 1'b0, 16'h0280, 1'b0);
        drain("t5_ch0_drain");
        chk("t5_coef_err_ch0", 32'(coef_err), 32'd0);
        send_pix(16'h0080, 1'b0, 16'hFF80, 1'b0);
        drain("t5_ch1_drain");
        chk("t5_coef_err_ch1", 32'(coef_err), 32'd1);
        repeat (3) step_idle();
        chk("t5_coef_err_sticky", 32'(coef_err), 32'd1);

        // Test 6b: reset mid-frame discards in-flight pixels, restarts at ch0
        send_pix(16'h1234, 1'b0, 16'h0000, 1'b0);
        send_pix(16'h1234, 1'b0, 16'h0000, 1'b0);
        send_pix(16'h1234, 1'b0, 16'h0000, 1'b0);
        do_reset("t6_reset");
        load_all(16'h0200, 16'h0080, 16'h0100, 16'hFF00);
        for (int i = 0; i < 4; i++) send_pix(16'h0100, 1'b0, 16'h0280, 1'b0);
        for (int i = 0; i < 4; i++) send_pix(16'h0080, 1'b0, 16'hFF80, (i == 3));
        drain("t6b_drain");
        chk("t6b_coef_err", 32'(coef_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
